fpga_mode_sequencer: RTL and testbench



---
 rtl/fpga_mode_pkg.sv | 36 +++
 rtl/fpga_mode_if.sv | 21 ++
 rtl/fpga_mode_sync_ff.sv | 23 ++
 rtl/fpga_mode_sequencer.sv | 144 ++++++++++++++
 tb/tb_fpga_mode_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fpga_mode_pkg.sv
// Shared state encoding, mode values, default cycle counts and output bundle
// for the FPGA mode changeover sequencer.
package fpga_mode_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] INIT     = 3'd0;
  localparam logic [ST_W-1:0] STABLE   = 3'd1;
  localparam logic [ST_W-1:0] DEBOUNCE = 3'd2;
  localparam logic [ST_W-1:0] WAIT_SPI = 3'd3;
  localparam logic [ST_W-1:0] QUIESCE  = 3'd4;
  localparam logic [ST_W-1:0] SWAP     = 3'd5;
  localparam logic [ST_W-1:0] SETTLE   = 3'd6;

  localparam logic MODE_HF = 1'b1;
  localparam logic MODE_LF = 1'b0;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1024;
  localparam int unsigned DEF_QUIESCE_CYCLES  = 256;
  localparam int unsigned DEF_RESET_CYCLES    = 16;
  localparam int unsigned DEF_CNT_W           = 16;

  typedef struct packed {
    logic mode_sel;
    logic hf_rst;
    logic lf_rst;
    logic out_blank;
    logic busy;
    logic mode_changed;
  } seq_out_t;

  localparam seq_out_t OUT_RST = '{mode_sel: MODE_LF, hf_rst: 1'b1, lf_rst: 1'b1,
                                   out_blank: 1'b1, busy: 1'b1, mode_changed: 1'b0};

endpackage

// File: rtl/fpga_mode_if.sv
// Mode strap / SPI select inputs and mux-select, core-reset and blanking outputs.
interface fpga_mode_if;
  logic fpga_switch_raw;
  logic ncs;
  logic mode_sel;
  logic hf_rst;
  logic lf_rst;
  logic out_blank;
  logic busy;
  logic mode_changed;

  modport master (
    output fpga_switch_raw, ncs,
    input  mode_sel, hf_rst, lf_rst, out_blank, busy, mode_changed
  );

  modport slave (
    input  fpga_switch_raw, ncs,
    output mode_sel, hf_rst, lf_rst, out_blank, busy, mode_changed
  );
endinterface

// File: rtl/fpga_mode_sync_ff.sv
// STAGES-deep synchroniser for an asynchronous board strap; reusable for other straps.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fpga_mode_sequencer.sv
// Debounces the HF/LF mode strap and performs a blanked, glitch-free mux
// select changeover followed by a held reset of the newly selected core.
module fpga_mode_sequencer
  import fpga_mode_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned QUIESCE_CYCLES  = DEF_QUIESCE_CYCLES,
  parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic         pck0,
  input  logic         rst,
  fpga_mode_if.slave   bus
);

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > CNT_SPAN) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (QUIESCE_CYCLES < 1 || 64'(QUIESCE_CYCLES) > CNT_SPAN) begin : g_bad_qui
    $error("QUIESCE_CYCLES out of range for CNT_W");
  end
  if (RESET_CYCLES < 1 || 64'(RESET_CYCLES) > CNT_SPAN) begin : g_bad_rst
    $error("RESET_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] QUI_LOAD = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_END = CNT_W'(SYNC_STAGES);

  logic             sw_s;
  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             from_init_q, from_init_d;
  seq_out_t         out_q, out_d;
  logic             hold;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (pck0),
    .rst (rst),
    .d   (bus.fpga_switch_raw),
    .q   (sw_s)
  );

  // Next state, counter and registered output values.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    from_init_d        = from_init_q;
    out_d              = out_q;
    out_d.mode_changed = 1'b0;
    cnt_dec            = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

    case (state_q)
      INIT: begin
        if (cnt_q == FILL_END) begin
          out_d.mode_sel = sw_s;
          cnt_d          = RST_LOAD;
          from_init_d    = 1'b1;
          state_d        = SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE: begin
        if (sw_s != out_q.mode_sel) begin
          cnt_d   = DEB_LOAD;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sw_s == out_q.mode_sel) state_d = STABLE;
        else if (cnt_q == '0)       state_d = WAIT_SPI;
        else                        cnt_d   = cnt_dec;
      end
      WAIT_SPI: begin
        if (bus.ncs) begin
          cnt_d   = QUI_LOAD;
          state_d = QUIESCE;
        end
      end
      QUIESCE: begin
        if (cnt_q == '0) begin
          out_d.mode_sel = ~out_q.mode_sel;
          state_d        = SWAP;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      SWAP: begin
        cnt_d       = RST_LOAD;
        from_init_d = 1'b0;
        state_d     = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          out_d.mode_changed = ~from_init_q;
          state_d            = STABLE;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = INIT;
      end
    endcase

    // Both cores held in reset around the swap; outputs blanked from QUIESCE on.
    hold            = (state_d == INIT) || (state_d == SWAP) || (state_d == SETTLE);
    out_d.out_blank = hold || (state_d == QUIESCE);
    out_d.hf_rst    = hold || (out_d.mode_sel != MODE_HF);
    out_d.lf_rst    = hold || (out_d.mode_sel != MODE_LF);
    out_d.busy      = (state_d != STABLE);
  end

  always_ff @(posedge pck0) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      from_init_q <= 1'b0;
      out_q       <= OUT_RST;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      from_init_q <= from_init_d;
      out_q       <= out_d;
    end
  end

  assign bus.mode_sel     = out_q.mode_sel;
  assign bus.hf_rst       = out_q.hf_rst;
  assign bus.lf_rst       = out_q.lf_rst;
  assign bus.out_blank    = out_q.out_blank;
  assign bus.busy         = out_q.busy;
  assign bus.mode_changed = out_q.mode_changed;

endmodule

// File: tb/tb_fpga_mode_sequencer.sv
// Directed bench for fpga_mode_sequencer with default parameters; inputs are
// driven and outputs sampled on the falling edge of pck0.
module tb_fpga_mode_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic seen_mc;

  fpga_mode_if bus ();

  fpga_mode_sequencer dut (
    .pck0 (clk),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance n cycles while recording whether mode_changed pulsed.
  task automatic tick_watch(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen = seen | bus.mode_changed;
    end
  endtask

  task automatic check_outs(input string tag, input logic sel, input logic hf,
                            input logic lf, input logic blank, input logic busy);
    check({tag, ".mode_sel"},  bus.mode_sel,  sel);
    check({tag, ".hf_rst"},    bus.hf_rst,    hf);
    check({tag, ".lf_rst"},    bus.lf_rst,    lf);
    check({tag, ".out_blank"}, bus.out_blank, blank);
    check({tag, ".busy"},      bus.busy,      busy);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.fpga_switch_raw = 1'b1;
    bus.ncs = 1'b1;

    // Reset state, then power-up into HF.
    tick(3);
    check_outs("rst", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst.mode_changed", bus.mode_changed, 1'b0);
    rst = 1'b0;
    tick(2);
    check("init_fill.mode_sel", bus.mode_sel, 1'b0);
    tick(1);
    check_outs("init_load", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick_watch(15, seen_mc);
    check_outs("init_settle_end", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    check_outs("init_stable", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("init_no_pulse", seen_mc | bus.mode_changed, 1'b0);

    // Clean HF->LF: first sampling edge is edge 1, select flips on edge 1+1283.
    bus.fpga_switch_raw = 1'b0;
    tick(1027);
    check_outs("hl_wait_spi", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1);
    check_outs("hl_quiesce", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(255);
    check("hl_preflip.mode_sel", bus.mode_sel, 1'b1);
    tick(1);
    check_outs("hl_swap", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick_watch(16, seen_mc);
    check_outs("hl_settle_end", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("hl_no_early_pulse", seen_mc, 1'b0);
    tick(1);
    check_outs("hl_stable", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hl_pulse", bus.mode_changed, 1'b1);
    tick(1);
    check("hl_pulse_end", bus.mode_changed, 1'b0);

    // 500-cycle glitch toward HF is rejected.
    bus.fpga_switch_raw = 1'b1;
    tick(250);
    check_outs("gl_mid", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(250);
    bus.fpga_switch_raw = 1'b0;
    tick(2);
    check("gl_abort_pending.busy", bus.busy, 1'b1);
    tick(1);
    check("gl_abort.busy", bus.busy, 1'b0);
    tick_watch(1500, seen_mc);
    check_outs("gl_after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("gl_no_pulse", seen_mc, 1'b0);

    // LF->HF while an SPI transaction stays open well past debounce.
    bus.ncs = 1'b0;
    bus.fpga_switch_raw = 1'b1;
    tick(1027 + 3000);
    check_outs("spi_held", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.ncs = 1'b1;
    tick(1);
    check_outs("spi_release", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(255);
    check("spi_preflip.mode_sel", bus.mode_sel, 1'b0);
    tick(1);
    check("spi_flip.mode_sel", bus.mode_sel, 1'b1);
    tick(17);
    check_outs("spi_stable", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("spi_pulse", bus.mode_changed, 1'b1);

    // Strap returns to HF during QUIESCE: swap completes, then swaps back.
    bus.fpga_switch_raw = 1'b0;
    tick(1028);
    check("tb_quiesce.out_blank", bus.out_blank, 1'b1);
    tick(100);
    bus.fpga_switch_raw = 1'b1;
    tick(155);
    check("tb_preflip.mode_sel", bus.mode_sel, 1'b1);
    tick(1);
    check("tb_flip.mode_sel", bus.mode_sel, 1'b0);
    tick(17);
    check_outs("tb_stable", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tb_pulse", bus.mode_changed, 1'b1);
    tick(1);
    check("tb_redebounce.busy", bus.busy, 1'b1);
    tick(1280);
    check("tb_preflip2.mode_sel", bus.mode_sel, 1'b0);
    tick(1);
    check("tb_flip2.mode_sel", bus.mode_sel, 1'b1);
    tick(17);
    check_outs("tb_stable2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset pulsed mid-QUIESCE, then power-up recovery into HF.
    bus.fpga_switch_raw = 1'b0;
    tick(1028 + 50);
    check("mr_quiesce.out_blank", bus.out_blank, 1'b1);
    rst = 1'b1;
    bus.fpga_switch_raw = 1'b1;
    tick(1);
    check_outs("mr_reset", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    tick(2);
    check("mr_fill.mode_sel", bus.mode_sel, 1'b0);
    tick(1);
    check("mr_load.mode_sel", bus.mode_sel, 1'b1);
    tick_watch(16, seen_mc);
    check_outs("mr_stable", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mr_no_pulse", seen_mc, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
